// File: rtl/shifter_pipe.sv
// -----------------------------------------------------------------------------
// shifter_pipe: pipelined barrel shifter/rotator with valid/ready flow control.
//
// The pipeline has L = log2(WIDTH) registered stages. Stage k applies a shift
// of 2^(L-1-k) when amount bit (L-1-k) is set, MSB first. The last stage
// drives the outputs. Stalls back up stage by stage, and a stage holding no
// valid data always loads from its predecessor, so bubbles collapse.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   flush      synchronous pipeline clear (drops any simultaneous input)
//   in_valid   operand valid
//   in_ready   shifter accepts input this cycle
//   in_data    operand [WIDTH]
//   in_amt     shift/rotate amount [AW]
//   in_op      000 rol, 001 sll, 010 ror, 011 srl, 100 sra, 101..111 srl
//   out_valid  result valid
//   out_ready  downstream accepts result
//   out_data   result [WIDTH]
//   out_zero   out_data is all zeros (0 whenever out_valid is 0)
//
// Optional feature macro: SHIFTER_PIPE_SRA_EN
//   defined   -> op 100 is an arithmetic right shift (sign carried per stage)
//   undefined -> op 100 behaves as srl and no sign is tracked
// -----------------------------------------------------------------------------
module shifter_pipe #(
    parameter  int unsigned WIDTH = 16,
    localparam int unsigned AW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AW-1:0]    in_amt,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero
);

    localparam int unsigned L = AW;

    typedef enum logic [2:0] {
        OP_ROL = 3'b000,
        OP_SLL = 3'b001,
        OP_ROR = 3'b010,
        OP_SRL = 3'b011,
        OP_SRA = 3'b100
    } op_e;

    // Stage registers
    logic [L-1:0]     r_v;
    logic [WIDTH-1:0] r_data [L];
    logic [AW-1:0]    r_amt  [L];
    op_e              r_op   [L];
`ifdef SHIFTER_PIPE_SRA_EN
    logic [L-1:0]     r_sgn;
`endif
    logic             r_zero;

    // Per-stage sources, shifted results and advance enables
    logic [L-1:0]     w_rdy;
    logic [L-1:0]     w_src_v;
    logic [WIDTH-1:0] w_src_data [L];
    logic [AW-1:0]    w_src_amt  [L];
    op_e              w_src_op   [L];
`ifdef SHIFTER_PIPE_SRA_EN
    logic [L-1:0]     w_src_sgn;
`endif
    logic [WIDTH-1:0] w_nxt_data [L];
    logic             w_nxt_zero;
    op_e              w_op_norm;

    // Fold unsupported op codes onto srl at the input
    always_comb begin
        w_op_norm = OP_SRL;
        case (in_op)
            3'b000:  w_op_norm = OP_ROL;
            3'b001:  w_op_norm = OP_SLL;
            3'b010:  w_op_norm = OP_ROR;
`ifdef SHIFTER_PIPE_SRA_EN
            3'b100:  w_op_norm = OP_SRA;
`endif
            default: w_op_norm = OP_SRL;
        endcase
    end

    // Ready chain from the output back to stage 0
    always_comb begin
        w_rdy        = '0;
        w_rdy[L-1]   = out_ready || !r_v[L-1];
        for (int k = int'(L) - 2; k >= 0; k--) begin
            w_rdy[k] = w_rdy[k+1] || !r_v[k];
        end
    end

    assign in_ready = w_rdy[0] && !flush;

    // Stage inputs: stage 0 from the ports, others from the previous stage
    always_comb begin
        w_src_v       = '0;
        w_src_v[0]    = in_valid && in_ready;
        w_src_data[0] = in_data;
        w_src_amt[0]  = in_amt;
        w_src_op[0]   = w_op_norm;
`ifdef SHIFTER_PIPE_SRA_EN
        w_src_sgn     = '0;
        w_src_sgn[0]  = in_data[WIDTH-1];
`endif
        for (int k = 1; k < int'(L); k++) begin
            w_src_v[k]    = r_v[k-1];
            w_src_data[k] = r_data[k-1];
            w_src_amt[k]  = r_amt[k-1];
            w_src_op[k]   = r_op[k-1];
`ifdef SHIFTER_PIPE_SRA_EN
            w_src_sgn[k]  = r_sgn[k-1];
`endif
        end
    end

    // Fixed-distance shift per stage, enabled by its amount bit
    always_comb begin
        for (int k = 0; k < int'(L); k++) begin
            w_nxt_data[k] = w_src_data[k];
            if (w_src_amt[k][int'(L) - 1 - k]) begin
                case (w_src_op[k])
                    OP_ROL:  w_nxt_data[k] = (w_src_data[k] << (1 << (int'(L) - 1 - k)))
                                           | (w_src_data[k] >> (int'(WIDTH) - (1 << (int'(L) - 1 - k))));
                    OP_ROR:  w_nxt_data[k] = (w_src_data[k] >> (1 << (int'(L) - 1 - k)))
                                           | (w_src_data[k] << (int'(WIDTH) - (1 << (int'(L) - 1 - k))));
                    OP_SLL:  w_nxt_data[k] = w_src_data[k] << (1 << (int'(L) - 1 - k));
`ifdef SHIFTER_PIPE_SRA_EN
                    // Fill vacated MSBs with the original operand sign
                    OP_SRA:  w_nxt_data[k] = (w_src_data[k] >> (1 << (int'(L) - 1 - k)))
                                           | (w_src_sgn[k] ? ~({WIDTH{1'b1}} >> (1 << (int'(L) - 1 - k)))
                                                           : {WIDTH{1'b0}});
`endif
                    default: w_nxt_data[k] = w_src_data[k] >> (1 << (int'(L) - 1 - k));
                endcase
            end
        end
    end

    // Zero flag is qualified by valid so it reads 0 for bubbles
    assign w_nxt_zero = w_src_v[L-1] && (w_nxt_data[L-1] == '0);

    // Pipeline registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v    <= '0;
            r_zero <= 1'b0;
`ifdef SHIFTER_PIPE_SRA_EN
            r_sgn  <= '0;
`endif
            for (int k = 0; k < int'(L); k++) begin
                r_data[k] <= '0;
                r_amt[k]  <= '0;
                r_op[k]   <= OP_ROL;
            end
        end else if (flush) begin
            r_v    <= '0;
            r_zero <= 1'b0;
        end else begin
            for (int k = 0; k < int'(L); k++) begin
                if (w_rdy[k]) begin
                    r_v[k]    <= w_src_v[k];
                    r_data[k] <= w_nxt_data[k];
                    r_amt[k]  <= w_src_amt[k];
                    r_op[k]   <= w_src_op[k];
`ifdef SHIFTER_PIPE_SRA_EN
                    r_sgn[k]  <= w_src_sgn[k];
`endif
                end
            end
            if (w_rdy[L-1]) begin
                r_zero <= w_nxt_zero;
            end
        end
    end

    assign out_valid = r_v[L-1];
    assign out_data  = r_data[L-1];
    assign out_zero  = r_zero;

endmodule

// File: tb/tb_shifter_pipe.sv
// -----------------------------------------------------------------------------
// tb_shifter_pipe: directed self-checking bench for shifter_pipe (WIDTH=16).
// Expected results are hand-computed constants in each scenario task.
// -----------------------------------------------------------------------------
module tb_shifter_pipe;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned AW    = 4;

    logic             clk;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [AW-1:0]    in_amt;
    logic [2:0]       in_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_zero;

    int n_checks = 0;
    int n_fail   = 0;

    shifter_pipe #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_zero  (out_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Send one operand into an empty pipeline and wait (bounded) for its result
    task automatic run_single(input logic [2:0] op, input logic [15:0] d, input logic [3:0] amt,
                              output logic [15:0] res, output logic z, output int lat);
        in_valid  = 1'b1;
        in_op     = op;
        in_data   = d;
        in_amt    = amt;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        lat      = 1;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        res = out_data;
        z   = out_zero;
        step();
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_amt    = '0;
        in_op     = '0;
        out_ready = 1'b1;
        #23;
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_checks++;
        if (out_data !== 16'h0000) begin n_fail++; $display("FAIL reset_out_data: got %h want 0000", out_data); end
        n_checks++;
        if (out_zero !== 1'b0) begin n_fail++; $display("FAIL reset_out_zero: got %b want 0", out_zero); end
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        step();
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready_cycle1: got %b want 1", in_ready); end
    endtask

    task automatic test_rotate();
        logic [15:0] r;
        logic        z;
        int          lat;
        run_single(3'b000, 16'h8001, 4'd1, r, z, lat);
        n_checks++;
        if (lat !== 4) begin n_fail++; $display("FAIL rol_latency: got %0d want 4", lat); end
        n_checks++;
        if (r !== 16'h0003) begin n_fail++; $display("FAIL rol_8001_1: got %h want 0003", r); end
        run_single(3'b010, 16'h0001, 4'd4, r, z, lat);
        n_checks++;
        if (r !== 16'h1000) begin n_fail++; $display("FAIL ror_0001_4: got %h want 1000", r); end
        run_single(3'b010, 16'h8001, 4'd1, r, z, lat);
        n_checks++;
        if (r !== 16'hC000) begin n_fail++; $display("FAIL ror_8001_1: got %h want c000", r); end
    endtask

    task automatic test_shift();
        logic [15:0] r;
        logic        z;
        int          lat;
        run_single(3'b011, 16'h8000, 4'd15, r, z, lat);
        n_checks++;
        if (r !== 16'h0001 || z !== 1'b0) begin n_fail++; $display("FAIL srl_8000_15: got %h zero %b want 0001 zero 0", r, z); end
        run_single(3'b001, 16'h00FF, 4'd8, r, z, lat);
        n_checks++;
        if (r !== 16'hFF00) begin n_fail++; $display("FAIL sll_00ff_8: got %h want ff00", r); end
        run_single(3'b001, 16'h00FF, 4'd12, r, z, lat);
        n_checks++;
        if (r !== 16'hF000) begin n_fail++; $display("FAIL sll_00ff_12: got %h want f000", r); end
        run_single(3'b001, 16'h0001, 4'd0, r, z, lat);
        n_checks++;
        if (r !== 16'h0001) begin n_fail++; $display("FAIL sll_0001_0: got %h want 0001", r); end
        run_single(3'b011, 16'h0001, 4'd1, r, z, lat);
        n_checks++;
        if (r !== 16'h0000 || z !== 1'b1) begin n_fail++; $display("FAIL srl_0001_1: got %h zero %b want 0000 zero 1", r, z); end
        run_single(3'b111, 16'h8000, 4'd3, r, z, lat);
        n_checks++;
        if (r !== 16'h1000) begin n_fail++; $display("FAIL op111_as_srl: got %h want 1000", r); end
    endtask

    task automatic test_sra();
        logic [15:0] r;
        logic        z;
        int          lat;
        logic [15:0] exp_neg;
`ifdef SHIFTER_PIPE_SRA_EN
        exp_neg = 16'hF000;
`else
        exp_neg = 16'h1000;
`endif
        run_single(3'b100, 16'h8000, 4'd3, r, z, lat);
        n_checks++;
        if (r !== exp_neg) begin n_fail++; $display("FAIL sra_8000_3: got %h want %h", r, exp_neg); end
        run_single(3'b100, 16'h4000, 4'd2, r, z, lat);
        n_checks++;
        if (r !== 16'h1000) begin n_fail++; $display("FAIL sra_4000_2: got %h want 1000", r); end
        run_single(3'b100, 16'h8001, 4'd0, r, z, lat);
        n_checks++;
        if (r !== 16'h8001) begin n_fail++; $display("FAIL sra_8001_0: got %h want 8001", r); end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  ops [6] = '{3'b000, 3'b010, 3'b001, 3'b011, 3'b000, 3'b011};
        logic [15:0] dat [6] = '{16'h1234, 16'h1234, 16'h1234, 16'h1234, 16'hF00F, 16'hFFFF};
        logic [3:0]  amt [6] = '{4'd4, 4'd4, 4'd4, 4'd4, 4'd8, 4'd15};
        logic [15:0] exp [6] = '{16'h2341, 16'h4123, 16'h2340, 16'h0123, 16'h0FF0, 16'h0001};
        int   idx = 0;
        int   got = 0;
        logic exp_rdy;
        for (int c = 0; c < 16; c++) begin
            out_ready = (c >= 4 && c <= 7) ? 1'b0 : 1'b1;
            if (idx < 6) begin
                in_valid = 1'b1;
                in_op    = ops[idx];
                in_data  = dat[idx];
                in_amt   = amt[idx];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (c < 10) begin
                exp_rdy = (c < 4 || c >= 8) ? 1'b1 : 1'b0;
                n_checks++;
                if (in_ready !== exp_rdy) begin n_fail++; $display("FAIL b2b_in_ready c%0d: got %b want %b", c, in_ready, exp_rdy); end
            end
            if (c >= 4 && c <= 7) begin
                n_checks++;
                if (out_valid !== 1'b1 || out_data !== 16'h2341) begin
                    n_fail++; $display("FAIL b2b_stall_hold c%0d: got valid %b data %h want 1 2341", c, out_valid, out_data);
                end
            end
            if (in_valid && in_ready) idx++;
            if (out_valid && out_ready) begin
                n_checks++;
                if (got >= 6) begin
                    n_fail++; $display("FAIL b2b_extra_result: got %h want none", out_data);
                end else if (out_data !== exp[got]) begin
                    n_fail++; $display("FAIL b2b_result%0d: got %h want %h", got, out_data, exp[got]);
                end
                got++;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        n_checks++;
        if (got !== 6) begin n_fail++; $display("FAIL b2b_count: got %0d want 6", got); end
    endtask

    task automatic test_flush();
        logic [15:0] r;
        logic        z;
        int          lat;
        int          seen = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_op    = 3'b001;
            in_data  = 16'h0010 + 16'(i);
            in_amt   = 4'd1;
            step();
        end
        in_data = 16'h00AA;
        flush   = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready: got %b want 0", in_ready); end
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid) seen++;
            step();
        end
        n_checks++;
        if (seen !== 0) begin n_fail++; $display("FAIL flush_no_output: got %0d valid cycles want 0", seen); end
        run_single(3'b000, 16'h00F0, 4'd4, r, z, lat);
        n_checks++;
        if (lat !== 4 || r !== 16'h0F00) begin n_fail++; $display("FAIL flush_next: got lat %0d data %h want 4 0f00", lat, r); end
    endtask

    task automatic test_reset_mid();
        logic [15:0] r;
        logic        z;
        int          lat;
        int          seen = 0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_op     = 3'b000;
        in_data   = 16'h8001;
        in_amt    = 4'd1;
        step();
        in_valid = 1'b0;
        step(); step(); step();
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 16'h0003) begin
            n_fail++; $display("FAIL stall_result: got valid %b data %h want 1 0003", out_valid, out_data);
        end
        in_valid = 1'b1;
        in_op    = 3'b011;
        in_data  = 16'hFFFF;
        in_amt   = 4'd1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bubble_collapse_ready: got %b want 1", in_ready); end
        step();
        in_valid = 1'b0;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== 16'h0000 || out_zero !== 1'b0) begin
            n_fail++; $display("FAIL async_reset: got valid %b data %h zero %b want 0 0000 0", out_valid, out_data, out_zero);
        end
        @(posedge clk);
        #2;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_ready: got %b want 1", in_ready); end
        for (int i = 0; i < 8; i++) begin
            step();
            if (out_valid) seen++;
        end
        n_checks++;
        if (seen !== 0) begin n_fail++; $display("FAIL stale_after_reset: got %0d valid cycles want 0", seen); end
        run_single(3'b010, 16'h8001, 4'd1, r, z, lat);
        n_checks++;
        if (lat !== 4 || r !== 16'hC000) begin n_fail++; $display("FAIL post_reset_op: got lat %0d data %h want 4 c000", lat, r); end
    endtask

    initial begin
        test_reset();
        test_rotate();
        test_shift();
        test_sra();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
